shared_track_arbiter: RTL
=========================

// Module: shared_track_arbiter
// PURPOSE
//  Arbitrates one shared single-track section between two trains (0 and 1).
//  Approach sensors V0/V1 request the section. The block lowers barrier B,
//  waits for it to settle, grants exactly one train (T0/T1) and holds the
//  grant until that train's exit sensor fires. It then enforces a clearance
//  gap before the next grant. Sits between the sensor inputs and the
//  signal/barrier drivers.
// PARAMETERS
//  CNT_W        8   width of the shared down-counter (all *_CYC must be < 2**CNT_W)
//  BARRIER_CYC  4   cycles spent in LOWER before a grant (>=1)
//  CLEAR_CYC    3   cycles spent in CLEAR after an exit (>=1)
//  TIMEOUT_CYC  50  max cycles in GRANT without an exit before FAULT (>=1)
// PORTS
//  clk     in   1  single clock, all logic on rising edge
//  reset   in   1  synchronous, active-high
//  V0      in   1  approach sensor / request, train 0 (level)
//  V1      in   1  approach sensor / request, train 1 (level)
//  E0      in   1  exit sensor, train 0 (only honoured while T0=1)
//  E1      in   1  exit sensor, train 1 (only honoured while T1=1)
//  T0      out  1  proceed signal, train 0 (registered)
//  T1      out  1  proceed signal, train 1 (registered)
//  B       out  1  barrier down (registered)
//  fault   out  1  grant timeout occurred, sticky until reset (registered)
//  status  out  2  00 free, 01 train0 on track, 10 train1 on track, 11 transition/fault
// BEHAVIOUR
//  Reset (synchronous, active-high):
//   - state=IDLE; T0=T1=B=fault=0; status=00.
//   - pend0=pend1=0; last_served=1, so train 0 wins the first tie.
//   - Asserting reset in any state, including FAULT, aborts the cycle in progress.
//  Requests:
//   - Effective request is req_x = pend_x | V_x.
//   - pend_x is set on any edge where V_x=1.
//   - pend_x of the served train is cleared on the edge that enters CLEAR.
//   - V_x of the served train is ignored while in CLEAR.
//  Selection:
//   - If only one train requests, that train is selected.
//   - If both request, the train != last_served is selected.
//   - last_served is updated on the edge that enters GRANT.
//  States:
//   IDLE
//    - Outputs: B=0, T=00, status=00.
//    - Any req -> LOWER on the same edge. Latch sel, load cnt=BARRIER_CYC-1, B=1.
//   LOWER
//    - Outputs: B=1, T=00, status=11.
//    - cnt==0 -> GRANT: T_sel=1, status=01/10, cnt=TIMEOUT_CYC-1.
//    - Otherwise cnt-1.
//    - Total time from B rising to T_sel rising is exactly BARRIER_CYC cycles.
//   GRANT
//    - Outputs: B=1, T_sel=1.
//    - E_sel=1 -> CLEAR: T=00, status=11, cnt=CLEAR_CYC-1.
//    - Otherwise, if cnt==0 -> FAULT.
//    - Otherwise cnt-1.
//    - Exit takes priority over timeout on the same edge.
//    - E of the non-selected train is ignored.
//   CLEAR
//    - Outputs: B=1, T=00.
//    - cnt==0 and the other train's req=1 -> GRANT for the other train directly
//      (barrier already down, no LOWER).
//    - cnt==0 and no req -> IDLE, B=0.
//    - Otherwise cnt-1.
//   FAULT
//    - Outputs: T=00, B=1, fault=1, status=11.
//    - Absorbing: only reset exits.
//  Invariants:
//   - T0 & T1 never both 1.
//   - T_x=1 implies B=1.
//  Counter: one CNT_W-bit down-counter shared by all timed states; no wrap-around is used.
// TESTING
//  1. Reset, then V0=1 at edge k.
//     -> B=1 after edge k, T0=1 after edge k+4, status=01.
//     -> E0 pulse: T0=0 next edge; B=0 three edges later; status=00.
//  2. Reset, then V0=V1=1 on the same edge.
//     -> Train 0 granted first.
//     -> After E0 and 3 CLEAR cycles, T1=1 with B held 1 throughout; status=10.
//  3. Grant to train 1, hold E1=0 for 50 cycles.
//     -> T1=0, fault=1, B=1, status=11.
//     -> Stays there under any V/E activity until reset; reset clears all outputs.
//  4. V1 pulsed for 1 cycle while train 0 is in GRANT.
//     -> pend1 latches; T1=1 exactly when CLEAR ends.
//  5. E1 asserted while T0 granted -> ignored, T0 stays 1.
//     E0 and timeout on the same edge -> CLEAR, not FAULT.
//  6. Reset asserted mid-LOWER and mid-GRANT -> next edge: IDLE, all outputs 0.
//     Throughout: check the T0&T1 and T->B invariants every cycle.

Source files
------------

// File: rtl/shared_track_arbiter.sv
// Grants one shared single-track section to one of two trains: lowers the barrier,
// grants one train until it exits, then holds a clearance gap before the next grant.
module shared_track_arbiter #(
  parameter int CNT_W       = 8,
  parameter int BARRIER_CYC = 4,
  parameter int CLEAR_CYC   = 3,
  parameter int TIMEOUT_CYC = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       V0,
  input  logic       V1,
  input  logic       E0,
  input  logic       E1,
  output logic       T0,
  output logic       T1,
  output logic       B,
  output logic       fault,
  output logic [1:0] status
);

  typedef enum logic [2:0] {S_IDLE, S_LOWER, S_GRANT, S_CLEAR, S_FAULT} state_t;

  localparam logic [CNT_W-1:0] BAR_LD = CNT_W'(BARRIER_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LD = CNT_W'(CLEAR_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LD  = CNT_W'(TIMEOUT_CYC - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sel;
  logic             r_last;
  logic             r_pend0;
  logic             r_pend1;

  logic w_v0, w_v1, w_req0, w_req1, w_pick, w_exit, w_oth_req, w_cnt_zero;

  // The served train is still sitting on its sensors during clearance; ignore it.
  assign w_v0       = V0 & ~((r_state == S_CLEAR) & ~r_sel);
  assign w_v1       = V1 & ~((r_state == S_CLEAR) &  r_sel);
  assign w_req0     = r_pend0 | w_v0;
  assign w_req1     = r_pend1 | w_v1;
  assign w_pick     = (w_req0 & w_req1) ? ~r_last : w_req1;
  assign w_exit     = r_sel ? E1 : E0;
  assign w_oth_req  = r_sel ? w_req0 : w_req1;
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      r_pend0 <= 1'b0;
      r_pend1 <= 1'b0;
      T0      <= 1'b0;
      T1      <= 1'b0;
      B       <= 1'b0;
      fault   <= 1'b0;
      status  <= 2'b00;
    end else begin
      if (w_v0) r_pend0 <= 1'b1;
      if (w_v1) r_pend1 <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_req0 | w_req1) begin
            r_state <= S_LOWER;
            r_sel   <= w_pick;
            r_cnt   <= BAR_LD;
            B       <= 1'b1;
            status  <= 2'b11;
          end
        end
        S_LOWER: begin
          if (w_cnt_zero) begin
            r_state <= S_GRANT;
            r_last  <= r_sel;
            T0      <= ~r_sel;
            T1      <= r_sel;
            status  <= r_sel ? 2'b10 : 2'b01;
            r_cnt   <= TO_LD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_GRANT: begin
          // Exit wins over a simultaneous timeout; this clear overrides the set above.
          if (w_exit) begin
            r_state <= S_CLEAR;
            T0      <= 1'b0;
            T1      <= 1'b0;
            status  <= 2'b11;
            r_cnt   <= CLR_LD;
            if (r_sel) r_pend1 <= 1'b0;
            else       r_pend0 <= 1'b0;
          end else if (w_cnt_zero) begin
            r_state <= S_FAULT;
            T0      <= 1'b0;
            T1      <= 1'b0;
            fault   <= 1'b1;
            status  <= 2'b11;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_CLEAR: begin
          if (w_cnt_zero) begin
            if (w_oth_req) begin
              // Barrier is already down, so hand over without lowering again.
              r_state <= S_GRANT;
              r_sel   <= ~r_sel;
              r_last  <= ~r_sel;
              T0      <= r_sel;
              T1      <= ~r_sel;
              status  <= r_sel ? 2'b01 : 2'b10;
              r_cnt   <= TO_LD;
            end else begin
              r_state <= S_IDLE;
              B       <= 1'b0;
              status  <= 2'b00;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_FAULT: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
